// File: rtl/hazard_stall_unit.sv
// Pipeline hazard detector: stall/flush requests for load-use, mul/div occupancy, memory wait and taken branches.
// Flow outputs are combinational, with zero latency. stall_cycles lags stall by one edge. mem_wait holds the whole pipe, and it has the highest priority.
module hazard_stall_unit #(
  parameter int REG_ADDR_W    = 5,
  parameter int MULDIV_CYCLES = 8,
  parameter int CNT_W         = 4,
  parameter int PERF_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_is_muldiv,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_wait,
  output logic                  stall,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic [1:0]            stall_cause,
  output logic [PERF_W-1:0]     stall_cycles
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic             MULTI_CYC = (MULDIV_CYCLES > 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;
  logic [PERF_W-1:0] perf_q;

  logic       lu;
  logic       rs1_hit, rs2_hit;
  logic       stall_raw, flush_if_id_raw, flush_id_ex_raw;
  logic [1:0] cause_raw;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
  assign lu      = id_valid && ex_mem_read && ex_reg_write && (ex_rd != '0) && (rs1_hit || rs2_hit);

  always_comb begin
    stall_raw       = 1'b0;
    flush_if_id_raw = 1'b0;
    flush_id_ex_raw = 1'b0;
    cause_raw       = 2'd0;
    state_d         = state_q;
    busy_cnt_d      = busy_cnt_q;

    if (mem_wait) begin
      stall_raw = 1'b1;
      cause_raw = 2'd3;
    end else if (state_q == BUSY) begin
      stall_raw = 1'b1;
      cause_raw = 2'd2;
    end else if (ex_branch_taken) begin
      // The ID instruction is wrong-path, so a pending load-use does not matter.
      flush_if_id_raw = 1'b1;
      flush_id_ex_raw = 1'b1;
    end else if (lu) begin
      stall_raw       = 1'b1;
      flush_id_ex_raw = 1'b1;
      cause_raw       = 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (MULTI_CYC && id_valid && id_is_muldiv && !stall_raw && !ex_branch_taken) begin
          state_d    = BUSY;
          busy_cnt_d = BUSY_LOAD;
        end
      end
      BUSY: begin
        // The unit keeps counting through mem_wait because it runs independently of the pipe.
        if (busy_cnt_q == CNT_W'(1)) begin
          state_d    = IDLE;
          busy_cnt_d = '0;
        end else begin
          busy_cnt_d = busy_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        busy_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_cnt_q <= '0;
      perf_q     <= '0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
      if (stall_raw && (perf_q != '1)) begin
        perf_q <= perf_q + PERF_W'(1);
      end
    end
  end

  assign stall        = stall_raw & ~rst;
  assign flush_if_id  = flush_if_id_raw & ~rst;
  assign flush_id_ex  = flush_id_ex_raw & ~rst;
  assign stall_cause  = rst ? 2'd0 : cause_raw;
  assign stall_cycles = rst ? '0 : perf_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit (MULDIV_CYCLES=8, PERF_W=4): the driver queues expectations, and the monitor checks them at negedge.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2;
  logic       id_uses_rs1, id_uses_rs2, id_is_muldiv;
  logic       ex_mem_read, ex_reg_write;
  logic [4:0] ex_rd;
  logic       ex_branch_taken, mem_wait;
  logic       stall, flush_if_id, flush_id_ex;
  logic [1:0] stall_cause;
  logic [3:0] stall_cycles;

  typedef struct {
    int         id;
    logic       stall;
    logic       fif;
    logic       fie;
    logic [1:0] cause;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   vec_id = 0;
  bit   stim_done = 1'b0;

  hazard_stall_unit #(
    .REG_ADDR_W(5), .MULDIV_CYCLES(8), .CNT_W(4), .PERF_W(4)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_muldiv(id_is_muldiv),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait), .stall(stall),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .stall_cause(stall_cause),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Monitor: every cycle is an output cycle for this block.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (stall !== e.stall || flush_if_id !== e.fif || flush_id_ex !== e.fie ||
          stall_cause !== e.cause || stall_cycles !== e.cnt) begin
        n_fail++;
        $display("FAIL vec%0d: got stall=%b fif=%b fie=%b cause=%0d cycles=%0d, want stall=%b fif=%b fie=%b cause=%0d cycles=%0d",
                 e.id, stall, flush_if_id, flush_id_ex, stall_cause, stall_cycles,
                 e.stall, e.fif, e.fie, e.cause, e.cnt);
      end
    end
  end

  task automatic clr();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_is_muldiv = 0; ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0;
    ex_branch_taken = 0; mem_wait = 0;
  endtask

  task automatic lu_setup();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd5;
    id_valid = 1; id_rs2 = 5'd5; id_uses_rs2 = 1;
  endtask

  task automatic step(input logic s, input logic fif, input logic fie,
                      input logic [1:0] c, input logic [3:0] n);
    exp_t e;
    e.id = vec_id; e.stall = s; e.fif = fif; e.fie = fie; e.cause = c; e.cnt = n;
    vec_id++;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clr(); rst = 1;
    step(0, 0, 0, 0, 0);
    rst = 0;
  endtask

  task automatic issue_muldiv();
    clr(); id_valid = 1; id_is_muldiv = 1;
  endtask

  initial begin
    clr(); rst = 1;
    @(posedge clk); #1;

    // Reset forces outputs low even with a hazard present.
    mem_wait = 1; lu_setup();
    step(0, 0, 0, 0, 0);
    clr(); rst = 0;

    // Load-use on rs2: one stall cycle, then EX is no longer a load.
    lu_setup();
    step(1, 0, 1, 1, 0);
    ex_mem_read = 0;
    step(0, 0, 0, 0, 1);
    // Filter on ex_rd==0 (rs2 is also 0), then filter on uses_rs2=0.
    lu_setup(); ex_rd = 0; id_rs2 = 0;
    step(0, 0, 0, 0, 1);
    lu_setup(); id_uses_rs2 = 0;
    step(0, 0, 0, 0, 1);
    // Match through rs1 instead of rs2.
    lu_setup(); id_uses_rs2 = 0; id_rs1 = 5'd5; id_uses_rs1 = 1;
    step(1, 0, 1, 1, 1);
    lu_setup(); id_valid = 0;
    step(0, 0, 0, 0, 2);

    // Mul/div occupancy: 7 busy cycles, then the pipe is free again.
    do_reset();
    issue_muldiv();
    step(0, 0, 0, 0, 0);
    clr();
    for (int k = 0; k < 7; k++) step(1, 0, 0, 2, 4'(k));
    step(0, 0, 0, 0, 7);

    // mem_wait during BUSY: the counter keeps running through the wait.
    do_reset();
    issue_muldiv();
    step(0, 0, 0, 0, 0);
    clr();
    step(1, 0, 0, 2, 0);
    mem_wait = 1;
    step(1, 0, 0, 3, 1);
    step(1, 0, 0, 3, 2);
    mem_wait = 0;
    for (int k = 3; k < 7; k++) step(1, 0, 0, 2, 4'(k));
    step(0, 0, 0, 0, 7);
    // mem_wait with load-use: memory wait wins, no bubble.
    lu_setup(); mem_wait = 1;
    step(1, 0, 0, 3, 7);
    // mem_wait with a mul/div in ID: it is not issued.
    issue_muldiv(); mem_wait = 1;
    step(1, 0, 0, 3, 8);
    clr();
    step(0, 0, 0, 0, 9);

    // A taken branch overrides load-use and blocks the mul/div issue.
    do_reset();
    lu_setup(); id_is_muldiv = 1; ex_branch_taken = 1;
    step(0, 1, 1, 0, 0);
    clr();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Reset in the 4th busy cycle aborts the sequence.
    do_reset();
    issue_muldiv();
    step(0, 0, 0, 0, 0);
    clr();
    step(1, 0, 0, 2, 0);
    step(1, 0, 0, 2, 1);
    step(1, 0, 0, 2, 2);
    rst = 1;
    step(0, 0, 0, 0, 0);
    rst = 0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Saturation with PERF_W=4: 20 stall cycles.
    do_reset();
    mem_wait = 1;
    for (int k = 0; k < 20; k++) step(1, 0, 0, 3, (k > 15) ? 4'd15 : 4'(k));
    mem_wait = 0;
    step(0, 0, 0, 0, 15);

    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!(stim_done && exp_q.size() == 0) && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    if (budget >= 2000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d expectations pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
